// File: rtl/pc_fetch_pkg.sv
// Shared types and defaults for the PC / instruction-fetch controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pc_fetch_pkg;

  // 32-bit machine word: PCs, fetch addresses and instruction words.
  typedef logic [31:0] word_t;

  localparam word_t       RESET_PC_DEF = 32'h0000_0000;
  localparam int unsigned INC_DEF      = 4;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/pc_incr_32.sv
// 32-bit constant incrementer, wraps modulo 2^32.
// Latency: combinational.
// Backpressure: none.
// Ports: i_a - operand; o_sum - i_a + INC.
module pc_incr_32
  import pc_fetch_pkg::*;
#(
  parameter int unsigned INC = INC_DEF
) (
  input  logic [31:0] i_a,
  output logic [31:0] o_sum
);

  assign o_sum = i_a + word_t'(INC);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC holder and instruction-fetch controller: issues word fetches, holds the fetched word for decode.
// Latency: ack in cycle N -> inst_valid in N+1; redirect in HOLD -> imem_addr = target next cycle.
// Backpressure: stall holds the instruction in HOLD; imem_ack paces fetches; stall is ignored while fetching.
//
// Ports: clk, rst_n (async, active-low); stall, redirect_valid/redirect_pc from decode and
// the next-PC mux; imem_req/imem_addr/imem_ack/imem_rdata to instruction memory;
// inst_valid/inst/inst_pc/pc_plus4 to decode; misalign_err pulse.
// Optional feature macro: PC_ALIGN_CHECK_EN (reject redirects that are not word aligned).
module pc_fetch_ctrl
  import pc_fetch_pkg::*;
#(
  parameter word_t       RESET_PC = RESET_PC_DEF,
  parameter int unsigned INC      = INC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] pc_plus4,
  output logic        misalign_err
);

  fetch_state_t r_state;
  word_t        r_pc;
  word_t        r_redir_pc;
  logic         r_redir_pend;
  logic         r_gap;        // one idle cycle after a redirected fetch completes
  word_t        r_inst;
  word_t        r_inst_pc;

  word_t        w_pc_inc;
  logic         w_redir_ok;
  logic         w_ack;

  pc_incr_32 #(.INC(INC)) u_pc_inc (
    .i_a   (r_pc),
    .o_sum (w_pc_inc)
  );

  pc_incr_32 #(.INC(INC)) u_plus4 (
    .i_a   (r_inst_pc),
    .o_sum (pc_plus4)
  );

`ifdef PC_ALIGN_CHECK_EN
  logic r_misalign;

  assign w_redir_ok = redirect_valid && (redirect_pc[1:0] == 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= redirect_valid && (redirect_pc[1:0] != 2'b00);
    end
  end

  assign misalign_err = r_misalign;
`else
  assign w_redir_ok   = redirect_valid;
  assign misalign_err = 1'b0;
`endif

  assign imem_req   = (r_state == ST_FETCH) && !r_gap;
  assign imem_addr  = r_pc;
  assign inst_valid = (r_state == ST_HOLD);
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;

  // An ack only counts against a live request; stray acks (e.g. late ones after reset) are dropped.
  assign w_ack = imem_ack && imem_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_BOOT;
      r_pc         <= RESET_PC;
      r_redir_pc   <= '0;
      r_redir_pend <= 1'b0;
      r_gap        <= 1'b0;
      r_inst       <= '0;
      r_inst_pc    <= '0;
    end else begin
      r_gap <= 1'b0;
      case (r_state)
        ST_BOOT: begin
          r_state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (w_ack) begin
            if (r_redir_pend || w_redir_ok) begin
              // The returned word belongs to the abandoned path; a same-cycle redirect beats the pended one.
              r_pc         <= w_redir_ok ? redirect_pc : r_redir_pc;
              r_redir_pend <= 1'b0;
              r_gap        <= 1'b1;
            end else begin
              r_inst    <= imem_rdata;
              r_inst_pc <= r_pc;
              r_pc      <= w_pc_inc;
              r_state   <= ST_HOLD;
            end
          end else if (w_redir_ok) begin
            // imem_addr must stay put until ack, so park the target; the last redirect wins.
            r_redir_pend <= 1'b1;
            r_redir_pc   <= redirect_pc;
          end
        end
        ST_HOLD: begin
          if (w_redir_ok) begin
            r_pc    <= redirect_pc;
            r_state <= ST_FETCH;
          end else if (!stall) begin
            r_state <= ST_FETCH;
          end
        end
        default: begin
          r_state <= ST_BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Randomized scoreboard bench for pc_fetch_ctrl.
// Latency: n/a (testbench).
// Backpressure: bench drives random stall and random imem_ack delays (0..3 cycles).
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] pc_plus4;
  logic        misalign_err;

  pc_fetch_ctrl #(.RESET_PC(32'h0000_0000), .INC(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .pc_plus4       (pc_plus4),
    .misalign_err   (misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int cyc; } req_exp_t;
  typedef struct { logic [31:0] pc; logic [31:0] ins; logic [31:0] p4; int cyc; } dlv_exp_t;

  req_exp_t req_q[$];
  dlv_exp_t dlv_q[$];

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   mon_en  = 1'b0;
  logic exp_mis = 1'b0;

  // Reference model: address of the current/next fetch, address of the held instruction,
  // pending redirect target, plus the memory responder's wait state.
  logic [31:0] m_addr = '0;
  logic [31:0] m_hold = '0;
  logic [31:0] m_pend = '0;
  bit          m_pend_vld = 1'b0;
  int          d_wait = 0;
  bit          d_busy = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] pick_target();
    logic [31:0] t;
    case ($urandom_range(0, 5))
      0: t = 32'h0000_0200;
      1: t = 32'h0000_0040;
      2: t = 32'hFFFF_FFFC;
      3: t = 32'h0000_0010;
      4: t = 32'h0000_0102;
      default: t = $urandom & 32'hFFFF_FFFC;
    endcase
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic fail_evt(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  bit          p_req = 1'b0;
  bit          p_val = 1'b0;
  logic [31:0] p_addr = '0;
  logic [31:0] p_inst = '0;
  logic [31:0] p_ipc = '0;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (mon_en) begin
      while (req_q.size() > 0 && req_q[0].cyc < cyc) begin
        fail_evt("req_overdue_addr", 32'hxxxx_xxxx, req_q[0].addr);
        void'(req_q.pop_front());
      end
      while (dlv_q.size() > 0 && dlv_q[0].cyc < cyc) begin
        fail_evt("inst_overdue_pc", 32'hxxxx_xxxx, dlv_q[0].pc);
        void'(dlv_q.pop_front());
      end
      if (imem_req) begin
        if (p_req && !imem_ack) begin
          check("addr_stable", imem_addr, p_addr);
        end else if (req_q.size() == 0) begin
          fail_evt("unexpected_req_addr", imem_addr, 32'hxxxx_xxxx);
        end else begin
          req_exp_t e;
          e = req_q.pop_front();
          check("req_addr", imem_addr, e.addr);
          check("req_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (inst_valid) begin
        if (p_val) begin
          check("hold_inst", inst, p_inst);
          check("hold_inst_pc", inst_pc, p_ipc);
        end else if (dlv_q.size() == 0) begin
          fail_evt("unexpected_inst_pc", inst_pc, 32'hxxxx_xxxx);
        end else begin
          dlv_exp_t d;
          d = dlv_q.pop_front();
          check("inst_pc", inst_pc, d.pc);
          check("inst", inst, d.ins);
          check("pc_plus4", pc_plus4, d.p4);
          check("inst_cycle", 32'(cyc), 32'(d.cyc));
        end
      end
      check("misalign_err", {31'd0, misalign_err}, {31'd0, exp_mis});
    end
    p_req  = imem_req;
    p_val  = inst_valid;
    p_addr = imem_addr;
    p_inst = inst;
    p_ipc  = inst_pc;
  end

  // One cycle of stimulus plus the matching reference-model update.
  task automatic step();
    bit r;
    bit v;
    bit acc;
    @(negedge clk);
    r = imem_req;
    v = inst_valid;
    imem_ack       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = $urandom;
    imem_rdata     = $urandom;
    stall          = v ? ($urandom_range(0, 2) != 0) : 1'($urandom_range(0, 1));
    if ((r || v) && $urandom_range(0, 5) == 0) begin
      redirect_valid = 1'b1;
      redirect_pc    = pick_target();
    end
    if (r) begin
      if (!d_busy) d_wait = $urandom_range(0, 3);
      if (d_wait == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        d_busy     = 1'b0;
      end else begin
        d_wait--;
        d_busy = 1'b1;
      end
    end
`ifdef PC_ALIGN_CHECK_EN
    acc     = redirect_valid && (redirect_pc[1:0] == 2'b00);
    exp_mis = redirect_valid && !acc;
`else
    acc     = redirect_valid;
    exp_mis = 1'b0;
`endif
    if (r) begin
      if (imem_ack) begin
        if (m_pend_vld || acc) begin
          // Fetched word is dropped; one idle cycle, then the redirect target is fetched.
          m_addr     = acc ? redirect_pc : m_pend;
          m_pend_vld = 1'b0;
          req_q.push_back('{m_addr, cyc + 2});
        end else begin
          dlv_q.push_back('{m_addr, mem_word(m_addr), m_addr + 32'd4, cyc + 1});
          m_hold = m_addr;
        end
      end else if (acc) begin
        m_pend     = redirect_pc;
        m_pend_vld = 1'b1;
      end
    end else if (v) begin
      if (acc) begin
        m_addr = redirect_pc;
        req_q.push_back('{m_addr, cyc + 1});
      end else if (!stall) begin
        m_addr = m_hold + 32'd4;
        req_q.push_back('{m_addr, cyc + 1});
      end
    end
  endtask

  task automatic reset_checks();
    check("rst_imem_req", {31'd0, imem_req}, 32'd0);
    check("rst_imem_addr", imem_addr, 32'h0000_0000);
    check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_pc_plus4", pc_plus4, 32'd4);
    check("rst_misalign", {31'd0, misalign_err}, 32'd0);
  endtask

  // Called at a falling edge: releases reset with a stray ack present during BOOT.
  task automatic release_reset();
    stall          = 1'b0;
    redirect_valid = 1'b0;
    imem_ack       = 1'b1;
    imem_rdata     = 32'hDEAD_BEEF;
    rst_n          = 1'b1;
    m_addr         = 32'h0000_0000;
    m_pend_vld     = 1'b0;
    d_busy         = 1'b0;
    exp_mis        = 1'b0;
    req_q.push_back('{32'h0000_0000, cyc + 1});
    mon_en         = 1'b1;
    #1;
    check("boot_no_req", {31'd0, imem_req}, 32'd0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    reset_checks();
    @(negedge clk);
    release_reset();
    run(3000);

    // Reset while a fetch is outstanding; its late ack must be ignored.
    for (int i = 0; i < 40 && !imem_req; i++) step();
    @(negedge clk);
    mon_en         = 1'b0;
    rst_n          = 1'b0;
    imem_ack       = 1'b1;
    redirect_valid = 1'b0;
    stall          = 1'b0;
    req_q.delete();
    dlv_q.delete();
    #1;
    reset_checks();
    repeat (2) @(negedge clk);
    release_reset();
    run(3000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
